mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
// - MEM-stage consumer of the lc3b_ipacket built at decode. Turns packet memory controls
//   (mem_read, mem_write, byte_op, opcode) into a handshaked data-memory access sequence.
// - Covers the two-access LDI/STI indirection and byte-lane steering for LDB/STB.
// - Holds the pipeline with stall while an access is outstanding.
// PARAMETERS
// - TIMEOUT_CYCLES  255  max cycles to wait for mem_resp per access (MEM_TIMEOUT_EN only)
// PORTS
// - clk           in   1             pipeline clock
// - reset         in   1             synchronous, active-high reset
// - valid_in      in   1             EX/MEM register holds a live packet
// - ipacket       in   lc3b_ipacket  packet from EX/MEM register
// - addr_in       in   16            ALU result (effective address)
// - sdata_in      in   16            store data (SR value)
// - mem_rdata     in   16            data memory read data
// - mem_resp      in   1             data memory access complete
// - mem_address   out  16            data memory address
// - mem_wdata     out  16            data memory write data
// - mem_read      out  1             read request
// - mem_write     out  1             write request
// - mem_byte_en   out  2             byte lane enables
// - load_data     out  16            load result (word, or zero-extended byte)
// - done          out  1             one-cycle pulse: sequence complete, load_data valid
// - stall         out  1             freeze IF..MEM stages
// - mem_err       out  1             one-cycle timeout pulse (MEM_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
// - Interface: one clock; synchronous active-high reset (clk, reset).
// - Reset: state IDLE; mem_read, mem_write, done, mem_err = 0; mem_byte_en = 2'b00;
//   mem_address, mem_wdata, load_data = 16'h0.
// - memop = valid_in & (ipacket.mem_read | ipacket.mem_write); indirect = opcode op_ldi/op_sti.
// - States: IDLE, ACCESS, INDIRECT, DONE.
// - IDLE -> ACCESS when memop; addr_in, sdata_in and the packet controls are latched.
//   Request is asserted the following cycle. Packets with no memop pass through; no stall.
// - ACCESS: mem_address = latched address.
//   - Word ops force bit0 = 0.
//   - If indirect: issue a word read. On mem_resp, capture mem_rdata as the new address
//     -> INDIRECT.
//   - Else: issue a read or write per the packet. On mem_resp -> DONE.
// - INDIRECT: mem_address = {captured[15:1], 1'b0}. LDI issues a read, STI a write of the
//   latched sdata. On mem_resp -> DONE.
// - Requests drop in the cycle after mem_resp is sampled. No back-to-back request without
//   one idle cycle.
// - Byte ops:
//   - mem_byte_en = addr[0] ? 2'b10 : 2'b01.
//   - STB: mem_wdata = {sdata[7:0], sdata[7:0]}.
//   - LDB: load_data = {8'h0, selected byte}.
//   - Word ops: mem_byte_en = 2'b11.
// - DONE: done = 1 for exactly one cycle; load_data holds the captured read (held until the
//   next capture); stall = 0; -> IDLE unconditionally.
// - stall = (state==ACCESS | state==INDIRECT) | (state==IDLE & memop). Latency: a
//   single-access op with mem_resp k cycles after the request gives done at request+k+1.
// - mem_resp in IDLE/DONE is ignored. valid_in/ipacket changes during ACCESS/INDIRECT are
//   ignored because the latched copy is used.
// - Reset mid-sequence: IDLE next cycle, requests deasserted, no done pulse.
// - mem_read and mem_write are never high together.
// CONFIGURATION
// - MEM_TIMEOUT_EN defined: counter cleared on each request start. If TIMEOUT_CYCLES elapse
//   without mem_resp:
//   - requests drop, mem_err pulses one cycle, state -> DONE;
//   - load_data = 16'h0 and done still pulses so the pipeline drains.
// - MEM_TIMEOUT_EN undefined: no counter; waits indefinitely; mem_err tied 0.
// TESTING
// - LDR addr_in=16'h3001, mem_rdata=16'hBEEF, resp 2 cycles after request
//   -> mem_address=16'h3000, byte_en=2'b11; done with load_data=16'hBEEF; stall for 4 cycles.
// - STB addr_in=16'h4001, sdata=16'h12A5 -> mem_write, byte_en=2'b10, wdata=16'hA5A5;
//   done pulse; load_data unchanged.
// - LDI addr_in=16'h5000, first rdata=16'h6002, second rdata=16'h0042
//   -> two reads (16'h5000 then 16'h6002); load_data=16'h0042.
// - STI addr_in=16'h5000, rdata=16'h7005, sdata=16'h1234
//   -> read 16'h5000, then write 16'h7004 with 16'h1234; never read and write together.
// - reset asserted during INDIRECT -> next cycle IDLE, mem_read=0, no done; spurious
//   mem_resp in IDLE has no effect.
// - MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_resp never asserted
//   -> mem_err and done pulse 8 cycles after request; load_data=16'h0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer for LC-3b loads/stores, including the two-access LDI/STI
// indirection and LDB/STB byte-lane steering. Define MEM_TIMEOUT_EN to add a per-access timeout.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode opcode;
        logic       mem_read;
        logic       mem_write;
        logic       byte_op;
    } lc3b_ipacket;

endpackage

module mem_stage_ctrl
    import lc3b_types::*;
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  lc3b_ipacket ipacket,
    input  logic [15:0] addr_in,
    input  logic [15:0] sdata_in,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_en,
    output logic [15:0] load_data,
    output logic        done,
    output logic        stall,
    output logic        mem_err
);

    localparam logic [1:0] S_IDLE     = 2'b00;
    localparam logic [1:0] S_ACCESS   = 2'b01;
    localparam logic [1:0] S_INDIRECT = 2'b10;
    localparam logic [1:0] S_DONE     = 2'b11;

    function automatic logic [1:0] byte_lanes(input logic is_byte, input logic hi);
        if (!is_byte) begin
            return 2'b11;
        end
        return hi ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [15:0] load_value(input logic [15:0] rdata, input logic is_byte,
                                               input logic hi);
        if (!is_byte) begin
            return rdata;
        end
        return hi ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
    endfunction

    logic [1:0]  state_q, state_d;
    logic        is_write_q, is_write_d;
    logic        is_byte_q, is_byte_d;
    logic        is_ind_q, is_ind_d;
    logic        sel_hi_q, sel_hi_d;
    logic [15:0] mem_address_q, mem_address_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [1:0]  mem_byte_en_q, mem_byte_en_d;
    logic [15:0] load_data_q, load_data_d;

    logic memop;
    logic indirect;
    logic pkt_byte;
    logic req_busy;
    logic timeout_hit;

    assign memop    = valid_in & (ipacket.mem_read | ipacket.mem_write);
    assign indirect = (ipacket.opcode == op_ldi) | (ipacket.opcode == op_sti);
    assign pkt_byte = ipacket.byte_op & ~indirect;
    assign req_busy = mem_read_q | mem_write_q;

`ifdef MEM_TIMEOUT_EN
    // Counter holds cycles spent waiting on the current request; it restarts on every new request.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             req_start;

    assign req_start   = (mem_read_d | mem_write_d) & ~req_busy;
    assign timeout_hit = req_busy & ~mem_resp & (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (req_start) begin
            cnt_d = '0;
        end else if (req_busy && !mem_resp && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign mem_err_d = timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        is_write_d    = is_write_q;
        is_byte_d     = is_byte_q;
        is_ind_d      = is_ind_q;
        sel_hi_d      = sel_hi_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_byte_en_d = mem_byte_en_q;
        load_data_d   = load_data_q;

        case (state_q)
            S_IDLE: begin
                if (memop) begin
                    state_d       = S_ACCESS;
                    is_write_d    = ipacket.mem_write;
                    is_byte_d     = pkt_byte;
                    is_ind_d      = indirect;
                    sel_hi_d      = addr_in[0];
                    mem_address_d = pkt_byte ? addr_in : {addr_in[15:1], 1'b0};
                    mem_wdata_d   = pkt_byte ? {sdata_in[7:0], sdata_in[7:0]} : sdata_in;
                    mem_byte_en_d = byte_lanes(pkt_byte, addr_in[0]);
                    // The first access of LDI/STI always fetches the pointer word.
                    mem_read_d    = indirect | ~ipacket.mem_write;
                    mem_write_d   = ~indirect & ipacket.mem_write;
                end
            end

            S_ACCESS: begin
                if (mem_resp) begin
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    mem_byte_en_d = 2'b00;
                    if (is_ind_q) begin
                        state_d       = S_INDIRECT;
                        mem_address_d = {mem_rdata[15:1], 1'b0};
                    end else begin
                        state_d = S_DONE;
                        if (mem_read_q) begin
                            load_data_d = load_value(mem_rdata, is_byte_q, sel_hi_q);
                        end
                    end
                end else if (timeout_hit) begin
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    mem_byte_en_d = 2'b00;
                    load_data_d   = 16'h0000;
                    state_d       = S_DONE;
                end
            end

            S_INDIRECT: begin
                // First cycle here is the mandatory idle gap between the two requests.
                if (!req_busy) begin
                    mem_read_d    = ~is_write_q;
                    mem_write_d   = is_write_q;
                    mem_byte_en_d = 2'b11;
                end else if (mem_resp) begin
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    mem_byte_en_d = 2'b00;
                    state_d       = S_DONE;
                    if (mem_read_q) begin
                        load_data_d = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    mem_byte_en_d = 2'b00;
                    load_data_d   = 16'h0000;
                    state_d       = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            is_write_q    <= 1'b0;
            is_byte_q     <= 1'b0;
            is_ind_q      <= 1'b0;
            sel_hi_q      <= 1'b0;
            mem_address_q <= 16'h0000;
            mem_wdata_q   <= 16'h0000;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_byte_en_q <= 2'b00;
            load_data_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            is_write_q    <= is_write_d;
            is_byte_q     <= is_byte_d;
            is_ind_q      <= is_ind_d;
            sel_hi_q      <= sel_hi_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_byte_en_q <= mem_byte_en_d;
            load_data_q   <= load_data_d;
        end
    end

    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_byte_en = mem_byte_en_q;
    assign load_data   = load_data_q;
    assign done        = (state_q == S_DONE);
    assign stall       = (state_q == S_ACCESS) | (state_q == S_INDIRECT) |
                         ((state_q == S_IDLE) & memop);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: table-driven single-access ops plus hand-written
// LDI/STI, reset-mid-sequence and (with MEM_TIMEOUT_EN) timeout sequences.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    lc3b_ipacket ipacket;
    logic [15:0] addr_in;
    logic [15:0] sdata_in;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_en;
    logic [15:0] load_data;
    logic        done;
    logic        stall;
    logic        mem_err;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stall) stall_cnt++;
    end

`ifdef MEM_TIMEOUT_EN
    mem_stage_ctrl #(.TIMEOUT_CYCLES(8)) dut (
`else
    mem_stage_ctrl dut (
`endif
        .clk(clk), .reset(reset), .valid_in(valid_in), .ipacket(ipacket),
        .addr_in(addr_in), .sdata_in(sdata_in), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_en(mem_byte_en), .load_data(load_data),
        .done(done), .stall(stall), .mem_err(mem_err)
    );

    typedef struct {
        lc3b_opcode  op;
        logic [15:0] addr;
        logic [15:0] sdata;
        logic [15:0] rdata;
        int          delay;
        logic [15:0] exp_addr;
        logic [1:0]  exp_be;
        logic [15:0] exp_wdata;
        logic [15:0] exp_load;
    } vec_t;

    vec_t vecs[7];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic lc3b_ipacket mk_pkt(input lc3b_opcode op);
        lc3b_ipacket p;
        p.opcode    = op;
        p.mem_read  = (op == op_ldr) || (op == op_ldb) || (op == op_ldi);
        p.mem_write = (op == op_str) || (op == op_stb) || (op == op_sti);
        p.byte_op   = (op == op_ldb) || (op == op_stb);
        return p;
    endfunction

    // Waits (bounded) for a request, checks it, then answers it after 'delay' cycles.
    task automatic access(input string name, input int delay, input logic [15:0] rdata,
                          input logic [15:0] exp_addr, input logic [1:0] exp_be,
                          input logic exp_rd, input logic exp_wr, input logic [15:0] exp_wdata);
        int n = 0;
        @(negedge clk);
        while (!(mem_read || mem_write) && n < 6) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk1({name, "_req_seen"}, mem_read | mem_write, 1'b1);
        chk1({name, "_rd"}, mem_read, exp_rd);
        chk1({name, "_wr"}, mem_write, exp_wr);
        chk1({name, "_rd_wr_excl"}, mem_read & mem_write, 1'b0);
        chk16({name, "_addr"}, mem_address, exp_addr);
        chk16({name, "_be"}, {14'h0, mem_byte_en}, {14'h0, exp_be});
        chk1({name, "_stall"}, stall, 1'b1);
        if (exp_wr) chk16({name, "_wdata"}, mem_wdata, exp_wdata);
        for (int i = 0; i < delay; i++) tick();
        mem_resp  = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = 16'hDEAD;
    endtask

    task automatic issue(input lc3b_opcode op, input logic [15:0] addr, input logic [15:0] sdata,
                         input string name);
        valid_in = 1'b1;
        ipacket  = mk_pkt(op);
        addr_in  = addr;
        sdata_in = sdata;
        @(negedge clk);
        chk1({name, "_stall_t0"}, stall, 1'b1);
        chk1({name, "_noreq_t0"}, mem_read | mem_write, 1'b0);
        tick();
        valid_in = 1'b0;
        ipacket  = mk_pkt(op_add);
        addr_in  = 16'hFFFF;
        sdata_in = 16'hFFFF;
    endtask

    task automatic finish_seq(input string name, input logic [15:0] exp_load);
        @(negedge clk);
        chk1({name, "_done"}, done, 1'b1);
        chk16({name, "_load"}, load_data, exp_load);
        chk1({name, "_done_stall"}, stall, 1'b0);
        chk1({name, "_done_noreq"}, mem_read | mem_write, 1'b0);
        tick();
        @(negedge clk);
        chk1({name, "_done_pulse"}, done, 1'b0);
        tick();
    endtask

    task automatic run_single(input vec_t v, input string name);
        lc3b_ipacket p;
        p = mk_pkt(v.op);
        issue(v.op, v.addr, v.sdata, name);
        access(name, v.delay, v.rdata, v.exp_addr, v.exp_be, p.mem_read, p.mem_write,
               v.exp_wdata);
        finish_seq(name, v.exp_load);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        vecs[0] = '{op_ldr, 16'h3001, 16'h0000, 16'hBEEF, 2, 16'h3000, 2'b11, 16'h0000, 16'hBEEF};
        vecs[1] = '{op_stb, 16'h4001, 16'h12A5, 16'h0000, 1, 16'h4001, 2'b10, 16'hA5A5, 16'hBEEF};
        vecs[2] = '{op_ldb, 16'h2001, 16'h0000, 16'h9C3E, 1, 16'h2001, 2'b10, 16'h0000, 16'h009C};
        vecs[3] = '{op_ldb, 16'h2000, 16'h0000, 16'h9C3E, 0, 16'h2000, 2'b01, 16'h0000, 16'h003E};
        vecs[4] = '{op_str, 16'h6003, 16'hCAFE, 16'h0000, 0, 16'h6002, 2'b11, 16'hCAFE, 16'h003E};
        vecs[5] = '{op_stb, 16'h4000, 16'h12A5, 16'h0000, 3, 16'h4000, 2'b01, 16'hA5A5, 16'h003E};
        vecs[6] = '{op_ldr, 16'h7FFF, 16'h0000, 16'h1234, 0, 16'h7FFE, 2'b11, 16'h0000, 16'h1234};

        reset     = 1'b1;
        valid_in  = 1'b0;
        ipacket   = mk_pkt(op_add);
        addr_in   = 16'h0000;
        sdata_in  = 16'h0000;
        mem_rdata = 16'h0000;
        mem_resp  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        @(negedge clk);
        chk1("rst_read", mem_read, 1'b0);
        chk1("rst_write", mem_write, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", mem_err, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk16("rst_be", {14'h0, mem_byte_en}, 16'h0000);
        chk16("rst_addr", mem_address, 16'h0000);
        chk16("rst_wdata", mem_wdata, 16'h0000);
        chk16("rst_load", load_data, 16'h0000);
        tick();

        // Non-memory packet passes straight through.
        valid_in = 1'b1;
        ipacket  = mk_pkt(op_add);
        addr_in  = 16'h1111;
        @(negedge clk);
        chk1("pass_stall", stall, 1'b0);
        tick();
        valid_in = 1'b0;
        @(negedge clk);
        chk1("pass_noreq", mem_read | mem_write, 1'b0);
        chk1("pass_nodone", done, 1'b0);
        tick();

        for (int i = 0; i < 7; i++) begin
            s0 = stall_cnt;
            run_single(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) chk16("ldr_stall_cycles", 16'(stall_cnt - s0), 16'd4);
        end

        // LDI: pointer read, one idle cycle, then data read at the pointer.
        issue(op_ldi, 16'h5000, 16'h0000, "ldi");
        access("ldi1", 1, 16'h6002, 16'h5000, 2'b11, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        chk1("ldi_gap_noreq", mem_read | mem_write, 1'b0);
        chk1("ldi_gap_stall", stall, 1'b1);
        chk1("ldi_gap_nodone", done, 1'b0);
        tick();
        access("ldi2", 0, 16'h0042, 16'h6002, 2'b11, 1'b1, 1'b0, 16'h0000);
        finish_seq("ldi", 16'h0042);

        // STI: pointer read, then word write to the aligned pointer.
        issue(op_sti, 16'h5000, 16'h1234, "sti");
        access("sti1", 0, 16'h7005, 16'h5000, 2'b11, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        chk1("sti_gap_noreq", mem_read | mem_write, 1'b0);
        tick();
        access("sti2", 2, 16'h0000, 16'h7004, 2'b11, 1'b0, 1'b1, 16'h1234);
        finish_seq("sti", 16'h0042);

`ifdef MEM_TIMEOUT_EN
        // No response: timeout after 8 waiting cycles, load_data forced to zero.
        begin
            int n = 0;
            issue(op_ldr, 16'h3000, 16'h0000, "tmo");
            @(negedge clk);
            while (!mem_read && n < 6) begin
                tick();
                @(negedge clk);
                n++;
            end
            chk1("tmo_req_seen", mem_read, 1'b1);
            repeat (7) tick();
            @(negedge clk);
            chk1("tmo_err_early", mem_err, 1'b0);
            chk1("tmo_done_early", done, 1'b0);
            chk1("tmo_req_held", mem_read, 1'b1);
            tick();
            @(negedge clk);
            chk1("tmo_err", mem_err, 1'b1);
            chk1("tmo_done", done, 1'b1);
            chk1("tmo_req_drop", mem_read, 1'b0);
            chk16("tmo_load", load_data, 16'h0000);
            tick();
            @(negedge clk);
            chk1("tmo_err_pulse", mem_err, 1'b0);
            tick();
        end
`endif

        // Reset while the second LDI request is outstanding.
        issue(op_ldi, 16'h5000, 16'h0000, "rmid");
        access("rmid1", 0, 16'h6002, 16'h5000, 2'b11, 1'b1, 1'b0, 16'h0000);
        tick();
        @(negedge clk);
        chk1("rmid_ind_req", mem_read, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk1("rmid_read", mem_read, 1'b0);
        chk1("rmid_done", done, 1'b0);
        chk1("rmid_stall", stall, 1'b0);
        chk16("rmid_load", load_data, 16'h0000);
        mem_resp  = 1'b1;
        mem_rdata = 16'h5555;
        tick();
        mem_resp = 1'b0;
        @(negedge clk);
        chk1("spur_done", done, 1'b0);
        chk1("spur_read", mem_read | mem_write, 1'b0);
        chk1("spur_stall", stall, 1'b0);
        chk16("spur_load", load_data, 16'h0000);
        tick();

        run_single(vecs[6], "post_reset_ldr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
